conv_scan_ctrl: RTL and testbench

Sequencer for the 3x3 convolution datapath: scans a row-major IMG_W x IMG_H image held in the input ROM, issues the nine tap reads per output pixel, and hands each tap to the convolution engine. It waits for the engine's result, then writes that result to the output ROM at the next row-major output address. It raises `write_fin` and then `write_fin_delay` at frame end. It sits in `top` between the input ROM, the convolution engine and the output ROM.

---
 rtl/conv_scan_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_conv_scan_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scan_ctrl.sv
// 3x3 convolution scan sequencer: walks the output pixels, issues nine tap reads each, writes engine results.
// Build option CONV_PAD_EN: zero-padded "same" output; default is "valid" output over interior centers.
module conv_scan_ctrl #(
  parameter int IMG_W  = 30,
  parameter int IMG_H  = 30,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              tap_valid,
  output logic              tap_zero,
  output logic [3:0]        tap_idx,
  output logic              tap_first,
  output logic              tap_last,
  input  logic              res_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              write_fin,
  output logic              write_fin_delay
);

  localparam int RW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(IMG_W + 1);
`ifdef CONV_PAD_EN
  localparam int R_FIRST = 0;
  localparam int R_LAST  = IMG_H - 1;
  localparam int C_FIRST = 0;
  localparam int C_LAST  = IMG_W - 1;
`else
  localparam int R_FIRST = 1;
  localparam int R_LAST  = IMG_H - 2;
  localparam int C_FIRST = 1;
  localparam int C_LAST  = IMG_W - 2;
`endif
  localparam logic [ADDR_W-1:0] W_STEP     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BASE_FIRST = ADDR_W'(R_FIRST * IMG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [RW-1:0]     row_reg;
  logic [CW-1:0]     col_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [ADDR_W-1:0] out_reg;
  logic [3:0]        k_reg;
  logic [1:0]        kx_reg;
  logic [1:0]        ky_reg;

  logic              tap_valid_reg;
  logic [3:0]        tap_idx_reg;
  logic              tap_first_reg;
  logic              tap_last_reg;
  logic              fin_delay_reg;

  logic              in_fetch;
  logic              last_tap;
  logic              last_col;
  logic              last_pixel;
  logic              tap_inside;
  logic [ADDR_W-1:0] tap_base;
  logic [ADDR_W-1:0] tap_addr;

  assign in_fetch   = (state_reg == S_FETCH);
  assign last_tap   = (k_reg == 4'd8);
  assign last_col   = (col_reg == CW'(C_LAST));
  assign last_pixel = last_col && (row_reg == RW'(R_LAST));

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: if (last_tap) state_next = S_WAIT;
      S_WAIT:  if (res_valid) state_next = S_WRITE;
      S_WRITE: state_next = last_pixel ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rom_en    = 1'b0;
    rom_addr  = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    write_fin = 1'b0;
    busy      = (state_reg != S_IDLE);
    case (state_reg)
      S_FETCH: begin
        rom_en   = tap_inside;
        rom_addr = tap_inside ? tap_addr : '0;
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = out_reg;
      end
      S_DONE:  write_fin = 1'b1;
      default: ;
    endcase
  end

  // Scan position: row base is kept as a running sum so no multiplier is needed.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      row_reg      <= '0;
      col_reg      <= '0;
      row_base_reg <= '0;
      out_reg      <= '0;
      k_reg        <= '0;
      kx_reg       <= '0;
      ky_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            row_reg      <= RW'(R_FIRST);
            col_reg      <= CW'(C_FIRST);
            row_base_reg <= BASE_FIRST;
            out_reg      <= '0;
            k_reg        <= '0;
            kx_reg       <= '0;
            ky_reg       <= '0;
          end
        end
        S_FETCH: begin
          if (last_tap) begin
            k_reg  <= '0;
            kx_reg <= '0;
            ky_reg <= '0;
          end else begin
            k_reg <= k_reg + 4'd1;
            if (kx_reg == 2'd2) begin
              kx_reg <= '0;
              ky_reg <= ky_reg + 2'd1;
            end else begin
              kx_reg <= kx_reg + 2'd1;
            end
          end
        end
        S_WRITE: begin
          out_reg <= out_reg + ADDR_W'(1);
          if (last_col) begin
            col_reg      <= CW'(C_FIRST);
            row_reg      <= row_reg + RW'(1);
            row_base_reg <= row_base_reg + W_STEP;
          end else begin
            col_reg <= col_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tap address: the underflowed top-row value is never used because such taps are masked.
  always_comb begin
    tap_base = row_base_reg;
    if (ky_reg == 2'd0) begin
      tap_base = row_base_reg - W_STEP;
    end else if (ky_reg == 2'd2) begin
      tap_base = row_base_reg + W_STEP;
    end
    tap_addr = tap_base + ADDR_W'(col_reg) + ADDR_W'(kx_reg) - ADDR_W'(1);
  end

`ifdef CONV_PAD_EN
  logic tap_zero_reg;

  always_comb begin
    tap_inside = 1'b1;
    if ((row_reg == '0) && (ky_reg == 2'd0)) tap_inside = 1'b0;
    if ((row_reg == RW'(IMG_H - 1)) && (ky_reg == 2'd2)) tap_inside = 1'b0;
    if ((col_reg == '0) && (kx_reg == 2'd0)) tap_inside = 1'b0;
    if ((col_reg == CW'(IMG_W - 1)) && (kx_reg == 2'd2)) tap_inside = 1'b0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tap_zero_reg <= 1'b0;
    end else begin
      tap_zero_reg <= in_fetch && !tap_inside;
    end
  end

  assign tap_zero = tap_zero_reg;
`else
  assign tap_inside = 1'b1;
  assign tap_zero   = 1'b0;
`endif

  // Tap sideband is delayed one cycle to line up with the ROM read data.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tap_valid_reg <= 1'b0;
      tap_idx_reg   <= '0;
      tap_first_reg <= 1'b0;
      tap_last_reg  <= 1'b0;
      fin_delay_reg <= 1'b0;
    end else begin
      tap_valid_reg <= in_fetch;
      tap_idx_reg   <= in_fetch ? k_reg : 4'd0;
      tap_first_reg <= in_fetch && (k_reg == 4'd0);
      tap_last_reg  <= in_fetch && last_tap;
      fin_delay_reg <= (state_reg == S_DONE);
    end
  end

  assign tap_valid       = tap_valid_reg;
  assign tap_idx         = tap_idx_reg;
  assign tap_first       = tap_first_reg;
  assign tap_last        = tap_last_reg;
  assign write_fin_delay = fin_delay_reg;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Scoreboard bench for conv_scan_ctrl: expected reads, taps and writes are queued per frame and popped as the DUT emits them.
module tb_conv_scan_ctrl;

  localparam int IMG_W  = 30;
  localparam int IMG_H  = 30;
  localparam int ADDR_W = 10;
`ifdef CONV_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int R0 = 0;
  localparam int R1 = IMG_H - 1;
  localparam int C0 = 0;
  localparam int C1 = IMG_W - 1;
`else
  localparam bit PAD = 1'b0;
  localparam int R0 = 1;
  localparam int R1 = IMG_H - 2;
  localparam int C0 = 1;
  localparam int C1 = IMG_W - 2;
`endif
  localparam int N_OUT = (R1 - R0 + 1) * (C1 - C0 + 1);

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              start = 1'b0;
  logic              res_valid = 1'b0;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              tap_valid;
  logic              tap_zero;
  logic [3:0]        tap_idx;
  logic              tap_first;
  logic              tap_last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              write_fin;
  logic              write_fin_delay;

  always #5 clk = ~clk;

  conv_scan_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstb(rstb), .start(start),
    .rom_en(rom_en), .rom_addr(rom_addr),
    .tap_valid(tap_valid), .tap_zero(tap_zero), .tap_idx(tap_idx),
    .tap_first(tap_first), .tap_last(tap_last),
    .res_valid(res_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .write_fin(write_fin), .write_fin_delay(write_fin_delay)
  );

  typedef struct {
    int idx;
    bit zero;
    bit first;
    bit last;
  } exp_tap_t;

  exp_tap_t tap_q[$];
  int       rd_q[$];
  int       wr_q[$];

  int       n_checks = 0;
  int       n_fail = 0;
  int       wr_cnt;
  bit       aborted;
  int       first_addr[9];
  int       n_first;
  logic [8:0] zmask;

  function automatic bit outs_zero();
    return (rom_en === 1'b0) && (rom_addr === '0) && (tap_valid === 1'b0) &&
           (tap_zero === 1'b0) && (tap_idx === 4'd0) && (tap_first === 1'b0) &&
           (tap_last === 1'b0) && (wr_en === 1'b0) && (wr_addr === '0) &&
           (busy === 1'b0) && (write_fin === 1'b0) && (write_fin_delay === 1'b0);
  endfunction

  // Reference scan computed directly from row/column coordinates.
  task automatic push_frame();
    int rr;
    int cc;
    bit ins;
    exp_tap_t t;
    tap_q.delete();
    rd_q.delete();
    wr_q.delete();
    for (int r = R0; r <= R1; r++) begin
      for (int c = C0; c <= C1; c++) begin
        for (int k = 0; k < 9; k++) begin
          rr = r + k / 3 - 1;
          cc = c + k % 3 - 1;
          ins = (rr >= 0) && (rr < IMG_H) && (cc >= 0) && (cc < IMG_W);
          t.idx = k;
          t.zero = PAD ? !ins : 1'b0;
          t.first = (k == 0);
          t.last = (k == 8);
          tap_q.push_back(t);
          if (ins) rd_q.push_back(rr * IMG_W + cc);
        end
        wr_q.push_back(wr_q.size());
      end
    end
  endtask

  task automatic drive_frame(input int slow_lat, input int n_slow, input bit spurious,
                             input bit start_busy, input int abort_pix);
    int cyc;
    int eng_cnt;
    int last_wr;
    int fin_cyc;
    int exp_addr;
    bit done;
    exp_tap_t t;
    push_frame();
    wr_cnt = 0;
    n_first = 0;
    zmask = '0;
    aborted = 1'b0;
    cyc = 0;
    eng_cnt = 0;
    last_wr = -10;
    fin_cyc = -10;
    done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        n_checks++;
        if (busy !== 1'b1 || rom_en !== !PAD) begin
          n_fail++;
          $display("FAIL start_latency: busy=%b rom_en=%b, required busy=1 rom_en=%b", busy, rom_en, !PAD);
        end
      end
      if (rom_en) begin
        n_checks++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rom_read: unexpected read of %0d, none required", rom_addr);
        end else begin
          exp_addr = rd_q.pop_front();
          if (rom_addr !== ADDR_W'(exp_addr)) begin
            n_fail++;
            $display("FAIL rom_addr: got %0d, required %0d (pixel %0d)", rom_addr, exp_addr, wr_cnt);
          end
        end
        if (wr_cnt == 0 && n_first < 9) begin
          first_addr[n_first] = int'(rom_addr);
          n_first++;
        end
      end
      if (tap_valid) begin
        n_checks++;
        if (tap_q.size() == 0) begin
          n_fail++;
          $display("FAIL tap_out: unexpected tap idx %0d, none required", tap_idx);
        end else begin
          t = tap_q.pop_front();
          if ({tap_idx, tap_zero, tap_first, tap_last} !== {4'(t.idx), t.zero, t.first, t.last}) begin
            n_fail++;
            $display("FAIL tap_out: got idx=%0d zero=%b first=%b last=%b, required idx=%0d zero=%b first=%b last=%b",
                     tap_idx, tap_zero, tap_first, tap_last, t.idx, t.zero, t.first, t.last);
          end
        end
        if (wr_cnt == 0 && tap_zero === 1'b1 && tap_idx < 4'd9) zmask[tap_idx] = 1'b1;
      end
      if (wr_en) begin
        n_checks++;
        if (res_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL wr_timing: wr_en=1 without res_valid the cycle before (res_valid=%b, required 1)", res_valid);
        end
        n_checks++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_addr: unexpected write to %0d, none required", wr_addr);
        end else begin
          exp_addr = wr_q.pop_front();
          if (wr_addr !== ADDR_W'(exp_addr)) begin
            n_fail++;
            $display("FAIL wr_addr: got %0d, required %0d", wr_addr, exp_addr);
          end
        end
        wr_cnt++;
        last_wr = cyc;
      end
      if (write_fin) begin
        n_checks++;
        if (cyc != last_wr + 1 || wr_q.size() != 0) begin
          n_fail++;
          $display("FAIL write_fin: at cycle %0d with %0d writes pending, required cycle %0d with 0 pending",
                   cyc, wr_q.size(), last_wr + 1);
        end
        fin_cyc = cyc;
      end
      if (write_fin_delay) begin
        n_checks++;
        if (cyc != fin_cyc + 1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL write_fin_delay: at cycle %0d busy=%b, required cycle %0d busy=0", cyc, busy, fin_cyc + 1);
        end
        done = 1'b1;
      end
      if (abort_pix >= 0 && wr_cnt == abort_pix && tap_valid && tap_idx == 4'd4) begin
        rstb = 1'b0;
        #1;
        n_checks++;
        if (!outs_zero()) begin
          n_fail++;
          $display("FAIL async_reset: outputs busy=%b rom_en=%b tap_valid=%b not all 0 right after rstb fell",
                   busy, rom_en, tap_valid);
        end
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          n_checks++;
          if ({write_fin, write_fin_delay, wr_en, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_quiet: fin=%b fin_d=%b wr_en=%b busy=%b, required all 0",
                     write_fin, write_fin_delay, wr_en, busy);
          end
        end
        rstb = 1'b1;
        aborted = 1'b1;
        done = 1'b1;
      end
      // Inputs for the next cycle: engine model plus deliberately ignored pulses.
      res_valid = 1'b0;
      start = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) res_valid = 1'b1;
      end
      if (tap_valid && tap_last) eng_cnt = (wr_cnt < n_slow) ? slow_lat : 3;
      if (spurious && tap_valid && tap_idx == 4'd3) res_valid = 1'b1;
      if (start_busy && wr_cnt == 5 && tap_valid && tap_idx == 4'd5) start = 1'b1;
      if (start_busy && wr_cnt == 6 && eng_cnt == 2) start = 1'b1;
    end
    res_valid = 1'b0;
    start = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL frame_timeout: %0d writes after %0d cycles, required frame end", wr_cnt, cyc);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (!outs_zero()) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b rom_en=%b tap_valid=%b, required all outputs 0", busy, rom_en, tap_valid);
    end
    rstb = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++;
      if (!outs_zero()) begin
        n_fail++;
        $display("FAIL idle_quiet: cycle %0d busy=%b rom_en=%b wr_en=%b, required all outputs 0", i, busy, rom_en, wr_en);
      end
    end
  endtask

  task automatic test_first_pixel_frame();
    int exp_first[9];
    int exp_n;
    logic [8:0] exp_zmask;
    if (PAD) begin
      exp_first = '{0, 1, 30, 31, 0, 0, 0, 0, 0};
      exp_n = 4;
      exp_zmask = 9'h04F;
    end else begin
      exp_first = '{0, 1, 2, 30, 31, 32, 60, 61, 62};
      exp_n = 9;
      exp_zmask = 9'h000;
    end
    drive_frame(3, 0, 1'b0, 1'b0, -1);
    n_checks++;
    if (n_first != exp_n) begin
      n_fail++;
      $display("FAIL first_read_count: got %0d reads for pixel 0, required %0d", n_first, exp_n);
    end
    for (int i = 0; i < exp_n && i < n_first; i++) begin
      n_checks++;
      if (first_addr[i] != exp_first[i]) begin
        n_fail++;
        $display("FAIL first_pixel_addr[%0d]: got %0d, required %0d", i, first_addr[i], exp_first[i]);
      end
    end
    n_checks++;
    if (zmask !== exp_zmask) begin
      n_fail++;
      $display("FAIL first_pixel_zero: got mask %h, required %h", zmask, exp_zmask);
    end
    n_checks++;
    if (wr_cnt != N_OUT) begin
      n_fail++;
      $display("FAIL frame_writes: got %0d, required %0d", wr_cnt, N_OUT);
    end
  endtask

  task automatic test_stall_ignored();
    drive_frame(20, 3, 1'b1, 1'b1, -1);
    n_checks++;
    if (wr_cnt != N_OUT) begin
      n_fail++;
      $display("FAIL stall_frame_writes: got %0d, required %0d", wr_cnt, N_OUT);
    end
  endtask

  task automatic test_reset_mid_frame();
    drive_frame(3, 0, 1'b0, 1'b0, 100);
    n_checks++;
    if (!aborted || wr_cnt != 100) begin
      n_fail++;
      $display("FAIL mid_reset: aborted=%b writes=%0d, required aborted=1 writes=100", aborted, wr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drive_frame(3, 0, 1'b0, 1'b0, -1);
    n_checks++;
    if (wr_cnt != N_OUT) begin
      n_fail++;
      $display("FAIL restart_writes: got %0d, required %0d", wr_cnt, N_OUT);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel_frame();
    test_stall_ignored();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
